gcm_ghash_seq: RTL and testbench

Upstream sequencer for `gcm_ghash`. It accepts AAD and ciphertext as a 32-bit word stream and packs the words into 128-bit blocks, zero-padding each segment's final partial block. It keeps running bit-length counters and drives the GHASH core's `init`/`next`/`x` handshake, including the closing len(A)||len(C) block. When the core finishes, it XORs the hash result with E(K,J0) to produce the GCM authentication tag.

---
 rtl/gcm_ghash_seq.sv | 148 ++++++++++++++
 tb/tb_gcm_ghash_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gcm_ghash_seq.sv
// gcm_ghash_seq: packs AAD/ciphertext words into 128-bit blocks and sequences a GHASH core into a GCM tag
// clk/reset_n: clock, async active-low reset; start/h_in/ekj0: begin message, capture H and E(K,J0)
// in_*: 32-bit word stream with byte count, type (0 AAD, 1 ciphertext) and segment end
// gh_*: init/next handshake to the GHASH core; tag/tag_valid: result; busy, err: status
module gcm_ghash_seq (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] h_in,
  input  logic [127:0] ekj0,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_type,
  input  logic         in_last,
  output logic         gh_init,
  output logic         gh_next,
  output logic [127:0] gh_h0,
  output logic [127:0] gh_x,
  input  logic [127:0] gh_y,
  input  logic         gh_ready,
  output logic [127:0] tag,
  output logic         tag_valid,
  output logic         busy,
  output logic         err
);
  typedef enum logic [3:0] {IDLE, INIT, WAIT_INIT, FILL, HASH, WAIT_HASH, LEN, WAIT_LEN, DONE} state_t;
  state_t state_q, state_d;
  logic [127:0] h_q, h_d, ek_q, ek_d, buf_q, buf_d, x_q, x_d, tag_q, tag_d;
  logic [63:0] len_a_q, len_a_d, len_c_q, len_c_d;
  logic [1:0] w_q, w_d;
  logic c_seen_q, c_seen_d, c_end_q, c_end_d, guard_q, guard_d;
  logic rdy_q, rdy_d, tv_q, tv_d, err_q, err_d;
  logic acc, hash_now;
  logic [2:0] nb;
  logic [31:0] wm;
  logic [127:0] buf_new;
  always_comb begin
    acc = in_valid & rdy_q;
    nb = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    wm = in_data & ~(32'hffff_ffff >> {nb, 3'b000});
    // every word occupies a 4-byte slot so the pointer stays word aligned
    buf_new = buf_q | ({wm, 96'd0} >> {w_q, 5'd0});
    hash_now = acc & ((w_q == 2'd3) | (in_last & ((w_q != 2'd0) | (nb != 3'd0))));
    gh_init = (state_q == INIT) & gh_ready;
    gh_next = ((state_q == HASH) | (state_q == LEN)) & gh_ready;
    // the core may still show ready in the cycle right after a pulse
    guard_d = gh_init | gh_next;
    state_d = state_q;
    h_d = h_q;
    ek_d = ek_q;
    buf_d = buf_q;
    w_d = w_q;
    x_d = x_q;
    tag_d = tag_q;
    tv_d = tv_q;
    len_a_d = len_a_q + ((acc & ~in_type) ? {58'd0, nb, 3'd0} : 64'd0);
    len_c_d = len_c_q + ((acc & in_type) ? {58'd0, nb, 3'd0} : 64'd0);
    c_seen_d = c_seen_q | (acc & in_type);
    c_end_d = c_end_q | (acc & in_type & in_last);
    err_d = err_q | (acc & ((in_bytes > 3'd4) | (~in_last & (in_bytes < 3'd4)) | (~in_type & c_seen_q)));
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = INIT;
        h_d = h_in;
        ek_d = ekj0;
        len_a_d = '0;
        len_c_d = '0;
        buf_d = '0;
        w_d = '0;
        c_seen_d = 1'b0;
        c_end_d = 1'b0;
        err_d = 1'b0;
        tv_d = 1'b0;
      end
      INIT: state_d = gh_ready ? WAIT_INIT : INIT;
      WAIT_INIT: state_d = (!guard_q && gh_ready) ? FILL : WAIT_INIT;
      FILL: if (hash_now) begin
        state_d = HASH;
        x_d = buf_new;
        buf_d = '0;
        w_d = '0;
      end else if (acc & in_last & in_type) begin
        state_d = LEN;
        x_d = {len_a_d, len_c_d};
      end else if (acc & ~in_last) begin
        buf_d = buf_new;
        w_d = w_q + 2'd1;
      end
      HASH: state_d = gh_ready ? WAIT_HASH : HASH;
      WAIT_HASH: if (!guard_q && gh_ready) begin
        state_d = c_end_q ? LEN : FILL;
        x_d = c_end_q ? {len_a_q, len_c_q} : x_q;
      end
      LEN: state_d = gh_ready ? WAIT_LEN : LEN;
      WAIT_LEN: if (!guard_q && gh_ready) begin
        state_d = DONE;
        tag_d = gh_y ^ ek_q;
        tv_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = state_d == FILL;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      h_q <= '0;
      ek_q <= '0;
      buf_q <= '0;
      x_q <= '0;
      tag_q <= '0;
      len_a_q <= '0;
      len_c_q <= '0;
      w_q <= '0;
      c_seen_q <= 1'b0;
      c_end_q <= 1'b0;
      guard_q <= 1'b0;
      rdy_q <= 1'b0;
      tv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      ek_q <= ek_d;
      buf_q <= buf_d;
      x_q <= x_d;
      tag_q <= tag_d;
      len_a_q <= len_a_d;
      len_c_q <= len_c_d;
      w_q <= w_d;
      c_seen_q <= c_seen_d;
      c_end_q <= c_end_d;
      guard_q <= guard_d;
      rdy_q <= rdy_d;
      tv_q <= tv_d;
      err_q <= err_d;
    end
  end
  assign in_ready = rdy_q;
  assign gh_h0 = h_q;
  assign gh_x = x_q;
  assign tag = tag_q;
  assign tag_valid = tv_q;
  assign err = err_q;
  assign busy = !((state_q == IDLE) || (state_q == DONE));
endmodule

// File: tb/tb_gcm_ghash_seq.sv
// tb_gcm_ghash_seq: directed vectors for gcm_ghash_seq against a behavioural GHASH core
module tb_gcm_ghash_seq;
  localparam logic [127:0] H1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EK1 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C1 = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] T1 = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] X3 = 128'h0123456789abcdeffedcba9876543210;
  logic clk = 0, reset_n = 0, start = 0;
  logic [127:0] h_in = '0, ekj0 = '0;
  logic in_valid = 0, in_type = 0, in_last = 0;
  logic [31:0] in_data = '0;
  logic [2:0] in_bytes = '0;
  logic in_ready, gh_init, gh_next, gh_ready, tag_valid, busy, err;
  logic [127:0] gh_h0, gh_x, gh_y, tag;
  logic [127:0] hk, yp, x_hold, cv;
  logic [127:0] xs[$];
  int n_vec = 0, n_bad = 0, viol_p = 0, viol_s = 0, lat = 3, cnt = 0;
  always #5 clk = ~clk;
  gcm_ghash_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .h_in(h_in), .ekj0(ekj0),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_bytes(in_bytes),
    .in_type(in_type), .in_last(in_last), .gh_init(gh_init), .gh_next(gh_next),
    .gh_h0(gh_h0), .gh_x(gh_x), .gh_y(gh_y), .gh_ready(gh_ready), .tag(tag),
    .tag_valid(tag_valid), .busy(busy), .err(err)
  );
  function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z, v;
    z = '0;
    v = b;
    for (int i = 127; i >= 0; i--) begin
      if (a[i]) z ^= v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
    end
    return z;
  endfunction
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      gh_ready <= 1'b1;
      gh_y <= '0;
      cnt <= 0;
    end else begin
      if ((gh_init | gh_next) & ~gh_ready) viol_p++;
      if (gh_init & gh_next) viol_p++;
      if (gh_init | gh_next) begin
        if (gh_init) hk <= gh_h0;
        yp <= gh_init ? 128'd0 : gmul(gh_y ^ gh_x, hk);
        if (gh_next) xs.push_back(gh_x);
        x_hold <= gh_x;
        gh_ready <= 1'b0;
        cnt <= lat;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          gh_ready <= 1'b1;
          gh_y <= yp;
        end
      end
    end
  always @(negedge clk)
    if (reset_n && !gh_ready && (in_ready || gh_x !== x_hold)) viol_s++;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  task automatic go(input logic [127:0] h, input logic [127:0] e);
    @(negedge clk);
    h_in = h;
    ekj0 = e;
    start = 1;
    xs.delete();
    @(negedge clk);
    start = 0;
    chk("init_pulse", {127'd0, gh_init}, 128'd1);
    chk("tv_clear", {127'd0, tag_valid}, 128'd0);
  endtask
  task automatic send(input logic [31:0] d, input logic [2:0] b, input logic t, input logic l);
    int n = 0;
    in_data = d;
    in_bytes = b;
    in_type = t;
    in_last = l;
    in_valid = 1;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("send_timeout", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic finish_msg();
    int n = 0;
    while (!tag_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("done", {127'd0, tag_valid}, 128'd1);
    chk("busy_done", {127'd0, busy}, 128'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("rst_flags", {122'd0, in_ready, gh_init, gh_next, tag_valid, busy, err}, 128'd0);
    chk("rst_tag", tag, 128'd0);
    go(H1, EK1);
    cv = C1;
    send(cv[127:96], 3'd4, 1'b1, 1'b0);
    reset_n = 0;
    #2;
    chk("midrst_flags", {122'd0, in_ready, gh_init, gh_next, tag_valid, busy, err}, 128'd0);
    chk("midrst_h0", gh_h0, 128'd0);
    chk("midrst_x", gh_x, 128'd0);
    @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);
    chk("post_rst", {126'd0, in_ready, busy}, 128'd0);
    go(H1, EK1);
    send(32'h0, 3'd0, 1'b1, 1'b1);
    finish_msg();
    chk("empty_n", 128'(xs.size()), 128'd1);
    chk("empty_x", xs[0], 128'd0);
    chk("empty_tag", tag, EK1);
    for (int p = 0; p < 2; p++) begin
      lat = p ? 10 : 3;
      go(H1, EK1);
      for (int i = 0; i < 4; i++) send(cv[127-32*i -: 32], 3'd4, 1'b1, i == 3);
      finish_msg();
      chk("c1_n", 128'(xs.size()), 128'd2);
      chk("c1_x0", xs[0], C1);
      chk("c1_len", xs[1], {64'd0, 64'd128});
      chk("c1_tag", tag, T1);
      chk("c1_err", {127'd0, err}, 128'd0);
      chk("c1_proto", 128'(viol_p + viol_s), 128'd0);
    end
    lat = 3;
    go(128'd0, X3);
    send(32'haabbccdd, 3'd3, 1'b0, 1'b1);
    send(32'h0, 3'd0, 1'b1, 1'b1);
    finish_msg();
    chk("aad_n", 128'(xs.size()), 128'd2);
    chk("aad_x0", xs[0], {32'haabbcc00, 96'd0});
    chk("aad_len", xs[1], {64'd24, 64'd0});
    chk("aad_tag", tag, X3);
    go(128'd0, X3);
    send(32'h11223344, 3'd2, 1'b0, 1'b0);
    chk("err_short", {127'd0, err}, 128'd1);
    send(32'h55667788, 3'd4, 1'b1, 1'b0);
    send(32'h99aabbcc, 3'd4, 1'b0, 1'b1);
    send(32'hddeeff00, 3'd4, 1'b1, 1'b1);
    finish_msg();
    chk("err_sticky", {127'd0, err}, 128'd1);
    chk("err_n", 128'(xs.size()), 128'd3);
    chk("err_x0", xs[0], 128'h11220000_55667788_99aabbcc_00000000);
    chk("err_x1", xs[1], {32'hddeeff00, 96'd0});
    chk("err_len", xs[2], {64'd48, 64'd64});
    chk("err_tag", tag, X3);
    go(128'd0, X3);
    chk("err_clear", {127'd0, err}, 128'd0);
    send(32'h01020304, 3'd7, 1'b1, 1'b1);
    finish_msg();
    chk("err_big", {127'd0, err}, 128'd1);
    chk("big_x0", xs[0], {32'h01020304, 96'd0});
    chk("big_len", xs[1], {64'd0, 64'd32});
    chk("proto", 128'(viol_p + viol_s), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
